// File: rtl/ysyx_25040111_mem_arb.sv
// Two-requester memory arbiter: LSU has priority over IFU, one registered transaction in flight.
// The optional WAIT-state watchdog is enabled by defining YSYX_25040111_ARB_TIMEOUT_EN.
module ysyx_25040111_mem_arb #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_write,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_mask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_mask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,

  output logic        arb_busy,
  output logic        arb_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  state_t      state, state_nxt;
  logic        owner;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_mask;

  logic        rsp_hit;
  logic        abort;
  logic        done;
  logic [31:0] rsp_data;

  assign lsu_req_ready = (state == ST_IDLE);
  assign ifu_req_ready = (state == ST_IDLE) && !lsu_req_valid;

  // Responses outside WAIT are dropped here, so a stray pulse reaches nobody.
  assign rsp_hit = (state == ST_WAIT) && mem_rsp_valid;

`ifdef YSYX_25040111_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if (state == ST_REQ) begin
      wait_cnt <= 16'd0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // A real response in the expiry cycle takes precedence over the abort.
  assign abort = (state == ST_WAIT) && !mem_rsp_valid && (wait_cnt == TIMEOUT - 16'd1);
`else
  assign abort = 1'b0;
`endif

  assign done     = rsp_hit || abort;
  assign rsp_data = abort ? 32'hDEAD_BEEF : mem_rdata;
  assign arb_err  = abort;

  assign ifu_rsp_valid = done && (owner == OWNER_IFU);
  assign lsu_rsp_valid = done && (owner == OWNER_LSU);
  assign ifu_rdata     = rsp_data;
  assign lsu_rdata     = rsp_data;

  assign mem_req_valid = (state == ST_REQ);
  assign mem_write     = req_write;
  assign mem_addr      = req_addr;
  assign mem_wdata     = req_wdata;
  assign mem_mask      = req_mask;
  assign arb_busy      = (state != ST_IDLE);

  always_comb begin
    // NOTE: next state defaults to the current one before the case, so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE: if (lsu_req_valid || ifu_req_valid) state_nxt = ST_REQ;
      ST_REQ:  if (mem_req_ready)                  state_nxt = ST_WAIT;
      ST_WAIT: if (done)                           state_nxt = ST_IDLE;
      default:                                     state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWNER_IFU;
      req_write <= 1'b0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_mask  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (lsu_req_valid) begin
          owner     <= OWNER_LSU;
          req_write <= lsu_write;
          req_addr  <= lsu_addr;
          req_wdata <= lsu_wdata;
          req_mask  <= lsu_mask;
        end else if (ifu_req_valid) begin
          owner     <= OWNER_IFU;
          req_write <= 1'b0;
          req_addr  <= ifu_addr;
          req_wdata <= 32'd0;
          req_mask  <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_mem_arb.sv
// Self-checking bench for ysyx_25040111_mem_arb: directed scenarios plus randomized transactions
// scored against a transaction-level latency model.
module tb_ysyx_25040111_mem_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr = 32'd0, ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_write = 1'b0, lsu_rsp_valid;
  logic [31:0] lsu_addr = 32'd0, lsu_wdata = 32'd0, lsu_rdata;
  logic [1:0]  lsu_mask = 2'b00;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_write, mem_rsp_valid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
  logic [1:0]  mem_mask;
  logic        arb_busy, arb_err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  ysyx_25040111_mem_arb #(.TIMEOUT(16'd8)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_write(lsu_write),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy), .arb_err(arb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at the following negedge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // One transaction from the accept cycle N: REQ spans N+1..N+1+dr (ready on the last),
  // WAIT spans dw idle cycles then the response cycle; IDLE again on the cycle after.
  task automatic txn(input bit iv, input bit lv, input logic [31:0] ia,
                     input bit lw, input logic [31:0] la, input logic [31:0] lwd,
                     input logic [1:0] lm, input int dr, input int dw, input logic [31:0] rd);
    bit          own_lsu = lv;
    bit          e_write = lv ? lw : 1'b0;
    logic [31:0] e_addr  = lv ? la : ia;
    logic [31:0] e_wdata = lv ? lwd : 32'd0;
    logic [1:0]  e_mask  = lv ? lm : 2'b10;
    bit          last;

    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_write = lw; lsu_addr = la; lsu_wdata = lwd; lsu_mask = lm;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clock);
    check("idle_busy", 32'(arb_busy), 32'd0);
    check("idle_mreq", 32'(mem_req_valid), 32'd0);
    check("idle_lsu_rdy", 32'(lsu_req_ready), 32'd1);
    check("idle_ifu_rdy", 32'(ifu_req_ready), 32'(!lv));
    next_cycle();
    if (own_lsu) lsu_req_valid = 1'b0;
    else         ifu_req_valid = 1'b0;

    for (int k = 0; k <= dr; k++) begin
      mem_req_ready = (k == dr);
      mem_rsp_valid = ($urandom_range(0, 3) == 0);
      mem_rdata     = $urandom;
      @(negedge clock);
      check("req_mreq", 32'(mem_req_valid), 32'd1);
      check("req_write", 32'(mem_write), 32'(e_write));
      check("req_addr", mem_addr, e_addr);
      check("req_wdata", mem_wdata, e_wdata);
      check("req_mask", 32'(mem_mask), 32'(e_mask));
      check("req_busy", 32'(arb_busy), 32'd1);
      check("req_rsp", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'd0);
      check("req_rdy", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
      next_cycle();
    end
    mem_req_ready = 1'b0;

    for (int k = 0; k <= dw; k++) begin
      last          = (k == dw);
      mem_rsp_valid = last;
      mem_rdata     = last ? rd : $urandom;
      @(negedge clock);
      check("wait_mreq", 32'(mem_req_valid), 32'd0);
      check("wait_busy", 32'(arb_busy), 32'd1);
      check("wait_ifu_rsp", 32'(ifu_rsp_valid), 32'(last && !own_lsu));
      check("wait_lsu_rsp", 32'(lsu_rsp_valid), 32'(last && own_lsu));
      check("wait_err", 32'(arb_err), 32'd0);
      if (last) check("rsp_data", own_lsu ? lsu_rdata : ifu_rdata, rd);
      next_cycle();
    end
    mem_rsp_valid = 1'b0;
  endtask

  // Accept an LSU load and let memory take it at once; returns with the arbiter in its first WAIT cycle.
  task automatic lsu_load_to_wait(input logic [31:0] addr);
    lsu_req_valid = 1'b1; lsu_write = 1'b0; lsu_addr = addr; lsu_wdata = 32'd0; lsu_mask = 2'b10;
    next_cycle();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
  endtask

  initial begin
    bit          pend;
    logic [31:0] paddr;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(arb_busy), 32'd0);
    check("rst_mreq", 32'(mem_req_valid), 32'd0);
    check("rst_fields", 32'({mem_write, mem_mask}), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rsp", 32'({ifu_rsp_valid, lsu_rsp_valid, arb_err}), 32'd0);
    next_cycle();
    reset = 1'b0;

    // IFU alone with zero-wait memory: accept N, request N+1, response N+2.
    txn(1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'd0, 32'd0, 2'b00, 0, 0, 32'h0010_0073);
    // Collision: LSU store first, the held IFU fetch is taken in the following IDLE cycle.
    txn(1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 32'h1234_5678, 2'b10, 0, 0, 32'h0);
    txn(1'b1, 1'b0, 32'h8000_0004, 1'b0, 32'd0, 32'd0, 2'b00, 0, 1, 32'hCAFE_0001);
    // Memory backpressure for five cycles.
    txn(1'b0, 1'b1, 32'd0, 1'b0, 32'h8000_2002, 32'hFFFF_0000, 2'b01, 5, 2, 32'hA5A5_5A5A);
    // Response on the last cycle before the watchdog would expire.
    txn(1'b0, 1'b1, 32'd0, 1'b1, 32'h8000_3003, 32'h0000_00EE, 2'b00, 1, 7, 32'h1111_2222);

    // Stray response while idle.
    mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clock);
    check("stray_rsp", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'd0);
    check("stray_busy", 32'(arb_busy), 32'd0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    check("stray_after_busy", 32'(arb_busy), 32'd0);
    next_cycle();

    // Reset while waiting for memory drops the transaction.
    lsu_load_to_wait(32'h8000_4000);
    reset = 1'b1;
    @(negedge clock);
    check("rstw_in_wait", 32'(arb_busy), 32'd1);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("rstw_busy", 32'(arb_busy), 32'd0);
    check("rstw_mreq", 32'(mem_req_valid), 32'd0);
    check("rstw_addr", mem_addr, 32'd0);
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clock);
    check("rstw_late_rsp", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'd0);
    next_cycle();
    mem_rsp_valid = 1'b0;

    // Memory that never answers.
    lsu_load_to_wait(32'h8000_5000);
`ifdef YSYX_25040111_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      mem_rdata = 32'h0BAD_0000 + 32'(k);
      @(negedge clock);
      check("to_lsu_rsp", 32'(lsu_rsp_valid), 32'(k == 8));
      check("to_err", 32'(arb_err), 32'(k == 8));
      check("to_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
      if (k == 8) check("to_rdata", lsu_rdata, 32'hDEAD_BEEF);
      next_cycle();
    end
    @(negedge clock);
    check("to_idle", 32'(arb_busy), 32'd0);
    next_cycle();
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      check("nto_busy", 32'(arb_busy), 32'd1);
      check("nto_rsp_err", 32'({lsu_rsp_valid, arb_err}), 32'd0);
      next_cycle();
    end
    mem_rsp_valid = 1'b1; mem_rdata = 32'h600D_600D;
    @(negedge clock);
    check("nto_late_rsp", 32'(lsu_rsp_valid), 32'd1);
    next_cycle();
    mem_rsp_valid = 1'b0;
`endif

    // Randomized traffic; a losing IFU request stays pending with the same address.
    pend = 1'b0; paddr = 32'd0;
    for (int i = 0; i < 40; i++) begin
      bit          lv = 1'($urandom_range(0, 1));
      bit          iv = pend ? 1'b1 : (lv ? 1'($urandom_range(0, 1)) : 1'b1);
      logic [31:0] ia = pend ? paddr : $urandom;
      txn(iv, lv, ia, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 2)),
          $urandom_range(0, 4), $urandom_range(0, 6), $urandom);
      pend  = iv && lv;
      paddr = ia;
    end
    if (pend) txn(1'b1, 1'b0, paddr, 1'b0, 32'd0, 32'd0, 2'b00, 0, 0, 32'h0F0F_0F0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
